// File: rtl/spectro_frame_rx_pkg.sv
// Shared constants, FSM encoding and RTC word helpers for the spectrogram frame receiver.
package spectro_frame_rx_pkg;

  localparam int WORD_W = 12;
  localparam int N_WORDS = 16;
  localparam int ADDR_W = 4;
  localparam int MASK_W = 16;
  localparam int CNT_W = 8;

  // RTC word (word 0) field split
  localparam int RTC_MIN_HI = 11;
  localparam int RTC_MIN_LO = 6;
  localparam int RTC_SEC_HI = 5;
  localparam int RTC_SEC_LO = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  function automatic logic [RTC_MIN_HI-RTC_MIN_LO:0] rtc_min(input logic [WORD_W-1:0] w);
    return w[RTC_MIN_HI:RTC_MIN_LO];
  endfunction

  function automatic logic [RTC_SEC_HI-RTC_SEC_LO:0] rtc_sec(input logic [WORD_W-1:0] w);
    return w[RTC_SEC_HI:RTC_SEC_LO];
  endfunction

endpackage

// File: rtl/spectro_frame_rx_if.sv
// Serializer link: bit stream, load strobe and word index.
interface spectro_frame_rx_if;
  logic       serial_in;
  logic       sl_in;
  logic [3:0] sel_in;

  modport master (output serial_in, sl_in, sel_in);
  modport slave  (input  serial_in, sl_in, sel_in);
endinterface

// File: rtl/spectro_frame_rx_sipo.sv
// Serial-to-parallel word shifter, MSB first, with bit counter.
module sipo_word_rx #(
  parameter int WORD_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift_en,
  input  logic              serial_in,
  output logic [WORD_W-1:0] word,
  output logic              last
);
  localparam int BC_W = $clog2(WORD_W + 1);

  logic [BC_W-1:0] bit_cnt;

  // shift one bit per enabled cycle; clear restarts the count for a new word
  always_ff @(posedge clk) begin
    if (!reset) begin
      word    <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      bit_cnt <= '0;
    end else if (shift_en) begin
      word    <= {word[WORD_W-2:0], serial_in};
      bit_cnt <= bit_cnt + BC_W'(1);
    end
  end

  // the sample taken this cycle completes the word
  assign last = (bit_cnt == BC_W'(WORD_W - 1));

endmodule

// File: rtl/spectro_frame_rx.sv
// Spectrogram frame receiver: collects serialized words into a capture buffer
// and publishes the whole frame when the last word index commits.
module spectro_frame_rx #(
  parameter int WORD_W  = spectro_frame_rx_pkg::WORD_W,
  parameter int N_WORDS = spectro_frame_rx_pkg::N_WORDS
) (
  input  logic                  clk,
  input  logic                  reset,
  spectro_frame_rx_if.slave     link,
  input  logic [3:0]            rd_addr,
  output logic [WORD_W-1:0]     rd_data,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic                  proto_err,
  output logic [7:0]            frame_cnt,
  output logic                  busy
);
  import spectro_frame_rx_pkg::*;

  state_t state, state_nx;
  logic [ADDR_W-1:0] waddr;
  logic restart, sample, abort, commit, publish, last, waddr_ok, raddr_ok;
  logic [WORD_W-1:0] word;
  logic [MASK_W-1:0] mask, mask_set;
  logic [N_WORDS-1:0][WORD_W-1:0] cap_buf, cap_nx, pub_buf;

  sipo_word_rx #(.WORD_W(WORD_W)) u_sipo (
    .clk      (clk),
    .reset    (reset),
    .clear    (restart),
    .shift_en (sample),
    .serial_in(link.serial_in),
    .word     (word),
    .last     (last)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // next state; a load strobe always wins, even mid-word (abort)
  always_comb begin
    state_nx = state;
    restart  = 1'b0;
    sample   = 1'b0;
    abort    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (link.sl_in) begin
          restart  = 1'b1;
          state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (link.sl_in) begin
          restart = 1'b1;
          abort   = 1'b1;
        end else begin
          sample = 1'b1;
          if (last) state_nx = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        if (link.sl_in) begin
          restart  = 1'b1;
          state_nx = ST_SHIFT;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign commit   = (state == ST_COMMIT);
  assign publish  = commit && (waddr == ADDR_W'(N_WORDS - 1));
  assign busy     = (state == ST_SHIFT);
  assign waddr_ok = ({1'b0, waddr} < 5'(N_WORDS));
  assign raddr_ok = ({1'b0, rd_addr} < 5'(N_WORDS));
  assign mask_set = mask | (MASK_W'(1) << waddr);

  // capture buffer with the committing word merged in, so a publish sees it
  always_comb begin
    cap_nx = cap_buf;
    if (waddr_ok) cap_nx[waddr] = word;
  end

  // word address latched on every load strobe
  always_ff @(posedge clk) begin
    if (!reset)       waddr <= '0;
    else if (restart) waddr <= link.sel_in;
  end

  // capture/publish buffers, received mask, frame counter and status pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      cap_buf     <= '0;
      pub_buf     <= '0;
      mask        <= '0;
      frame_cnt   <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      proto_err   <= abort;
      if (commit) begin
        cap_buf <= cap_nx;
        if (publish) begin
          pub_buf     <= cap_nx;
          mask        <= '0;
          frame_valid <= 1'b1;
          frame_err   <= ~&mask_set[N_WORDS-1:0];
          frame_cnt   <= frame_cnt + 8'd1;
        end else begin
          mask <= mask_set;
        end
      end
    end
  end

  // registered read port; a same-edge publish is not yet visible
  always_ff @(posedge clk) begin
    if (!reset)        rd_data <= '0;
    else if (raddr_ok) rd_data <= pub_buf[rd_addr];
    else               rd_data <= '0;
  end

endmodule

// File: tb/tb_spectro_frame_rx.sv
// Self-checking bench for spectro_frame_rx against a frame-level reference model.
module tb_spectro_frame_rx;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rd_addr;
  logic [11:0] rd_data;
  logic        frame_valid, frame_err, proto_err, busy;
  logic [7:0]  frame_cnt;

  spectro_frame_rx_if link();

  spectro_frame_rx #(.WORD_W(12), .N_WORDS(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .link       (link),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .proto_err  (proto_err),
    .frame_cnt  (frame_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fv_seen = 0, pe_seen = 0, fe_seen = 0;

  // pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (frame_valid) fv_seen++;
    if (frame_valid && frame_err) fe_seen++;
    if (proto_err) pe_seen++;
  end

  // reference model: what the receiver should hold, at frame level
  logic [11:0] m_cap [16];
  logic [11:0] m_pub [16];
  logic [15:0] m_mask;
  int          m_cnt;
  logic        m_err;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin m_cap[i] = '0; m_pub[i] = '0; end
    m_mask = '0; m_cnt = 0; m_err = 1'b0;
  endtask

  task automatic model_commit(input int a, input logic [11:0] d);
    m_cap[a] = d;
    m_mask[a] = 1'b1;
    if (a == 15) begin
      m_err = (m_mask != 16'hFFFF);
      for (int i = 0; i < 16; i++) m_pub[i] = m_cap[i];
      m_mask = '0;
      m_cnt = (m_cnt + 1) % 256;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic quiet();
    step();
    link.sl_in = 1'b0; link.serial_in = 1'b0;
  endtask

  // load strobe then n bits, MSB first; the next step lands in COMMIT
  task automatic send_bits(input int sel, input logic [11:0] d, input int n);
    step();
    link.sl_in = 1'b1; link.sel_in = sel[3:0]; link.serial_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      link.sl_in = 1'b0; link.serial_in = d[11-i];
    end
  endtask

  task automatic send_word(input int sel, input logic [11:0] d);
    send_bits(sel, d, 12);
    model_commit(sel, d);
  endtask

  task automatic read_word(input int a, output logic [11:0] d);
    rd_addr = a[3:0];
    step();
    d = rd_data;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    link.sl_in = 1'b0; link.serial_in = 1'b0; link.sel_in = '0;
    step(); step();
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [11:0] d;
    do_reset();
    step();
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b exp 0", frame_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b exp 0", frame_err); end
    checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b exp 0", proto_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", frame_cnt); end
    for (int k = 0; k < 16; k += 5) begin
      read_word(k, d);
      checks++; if (d !== 12'h000) begin errors++; $display("FAIL reset_rd[%0d]: got %h exp 000", k, d); end
    end
  endtask

  task automatic test_full_frame();
    logic [11:0] old7, d;
    for (int k = 0; k < 15; k++) send_word(k, 12'h100 + 12'(k));
    old7 = m_pub[7];
    send_word(15, 12'h10F);
    rd_addr = 4'd7;
    quiet();  // COMMIT of word 15
    step();
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL full_fv: got %b exp 1", frame_valid); end
    checks++; if (frame_err !== m_err) begin errors++; $display("FAIL full_ferr: got %b exp %b", frame_err, m_err); end
    checks++; if (frame_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL full_cnt: got %0d exp %0d", frame_cnt, m_cnt); end
    checks++; if (rd_data !== old7) begin errors++; $display("FAIL full_prepub_rd: got %h exp %h", rd_data, old7); end
    step();
    checks++; if (rd_data !== 12'h107) begin errors++; $display("FAIL full_rd7: got %h exp 107", rd_data); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL full_fv_pulse: got %b exp 0", frame_valid); end
    for (int k = 0; k < 16; k += 3) begin
      read_word(k, d);
      checks++; if (d !== m_pub[k]) begin errors++; $display("FAIL full_rd[%0d]: got %h exp %h", k, d, m_pub[k]); end
    end
  endtask

  task automatic test_missing();
    logic [11:0] d;
    for (int k = 0; k < 16; k++) if (k != 9) send_word(k, 12'($urandom));
    quiet(); step();
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL miss_fv: got %b exp 1", frame_valid); end
    checks++; if (frame_err !== m_err) begin errors++; $display("FAIL miss_ferr: got %b exp %b", frame_err, m_err); end
    for (int k = 0; k < 16; k++) begin
      read_word(k, d);
      checks++; if (d !== m_pub[k]) begin errors++; $display("FAIL miss_rd[%0d]: got %h exp %h", k, d, m_pub[k]); end
    end
    // only words 9 and 15 follow: the frame is incomplete only if the mask was cleared
    send_word(9, 12'($urandom));
    send_word(15, 12'($urandom));
    quiet(); step();
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL miss2_fv: got %b exp 1", frame_valid); end
    checks++; if (frame_err !== m_err) begin errors++; $display("FAIL miss2_ferr: got %b exp %b", frame_err, m_err); end
  endtask

  task automatic test_abort();
    logic [11:0] d;
    int pe0;
    pe0 = pe_seen;
    send_bits(3, 12'($urandom), 5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy: got %b exp 1", busy); end
    send_word(4, 12'hABC);
    for (int k = 0; k < 16; k++) if (k != 3 && k != 4) send_word(k, 12'($urandom));
    quiet(); step(); step();
    checks++; if (pe_seen - pe0 !== 1) begin errors++; $display("FAIL abort_perr_pulses: got %0d exp 1", pe_seen - pe0); end
    read_word(4, d);
    checks++; if (d !== 12'hABC) begin errors++; $display("FAIL abort_rd4: got %h exp abc", d); end
    read_word(3, d);
    checks++; if (d !== m_pub[3]) begin errors++; $display("FAIL abort_rd3: got %h exp %h", d, m_pub[3]); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] d;
    int fe0;
    fe0 = fe_seen;
    for (int k = 0; k < 16; k++) send_word(k, 12'($urandom));
    quiet(); step();
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL b2b_fv: got %b exp 1", frame_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL b2b_ferr: got %b exp 0", frame_err); end
    checks++; if (frame_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL b2b_cnt: got %0d exp %0d", frame_cnt, m_cnt); end
    for (int k = 0; k < 16; k++) begin
      read_word(k, d);
      checks++; if (d !== m_pub[k]) begin errors++; $display("FAIL b2b_rd[%0d]: got %h exp %h", k, d, m_pub[k]); end
    end
    checks++; if (fe_seen !== fe0) begin errors++; $display("FAIL b2b_err_pulses: got %0d exp %0d", fe_seen, fe0); end
  endtask

  task automatic test_random();
    logic [11:0] d;
    int a;
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < 15; k++) begin
        if ($urandom_range(9, 0) < 8) send_word(k, 12'($urandom));
        if ($urandom_range(3, 0) == 0) send_word(k, 12'($urandom)); // overwrite
        for (int g = $urandom_range(2, 0); g > 0; g--) quiet();
      end
      send_word(15, 12'($urandom));
      quiet(); step();
      checks++; if (frame_err !== m_err || frame_valid !== 1'b1) begin
        errors++; $display("FAIL rnd_ferr[%0d]: got v=%b e=%b exp v=1 e=%b", f, frame_valid, frame_err, m_err);
      end
      for (int r = 0; r < 4; r++) begin
        a = $urandom_range(15, 0);
        read_word(a, d);
        checks++; if (d !== m_pub[a]) begin errors++; $display("FAIL rnd_rd[%0d]: got %h exp %h", a, d, m_pub[a]); end
      end
    end
  endtask

  task automatic test_midword_reset();
    logic [11:0] d;
    send_bits(2, 12'($urandom), 6);
    step();
    reset = 1'b0; link.sl_in = 1'b0; link.serial_in = 1'b0;
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy: got %b exp 0", busy); end
    checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL mrst_cnt: got %0d exp 0", frame_cnt); end
    checks++; if (rd_data !== 12'h000) begin errors++; $display("FAIL mrst_rd: got %h exp 000", rd_data); end
    checks++; if ({frame_valid, frame_err, proto_err} !== 3'b000) begin
      errors++; $display("FAIL mrst_flags: got %b exp 000", {frame_valid, frame_err, proto_err});
    end
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 14; i++) quiet();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_no_resume: got busy %b exp 0", busy); end
    send_word(15, 12'($urandom));
    quiet(); step();
    checks++; if (frame_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL mrst_cnt2: got %0d exp %0d", frame_cnt, m_cnt); end
    checks++; if (frame_err !== m_err) begin errors++; $display("FAIL mrst_ferr: got %b exp %b", frame_err, m_err); end
    read_word(2, d);
    checks++; if (d !== m_pub[2]) begin errors++; $display("FAIL mrst_rd2: got %h exp %h", d, m_pub[2]); end
  endtask

  task automatic test_wrap();
    int fv0, fe0;
    do_reset();
    fv0 = fv_seen; fe0 = fe_seen;
    for (int f = 0; f < 256; f++)
      for (int k = 0; k < 16; k++) send_word(k, 12'($urandom));
    quiet(); step(); step();
    checks++; if (frame_cnt !== 8'(m_cnt)) begin errors++; $display("FAIL wrap_cnt: got %0d exp %0d", frame_cnt, m_cnt); end
    checks++; if (fv_seen - fv0 !== 256) begin errors++; $display("FAIL wrap_fv_pulses: got %0d exp 256", fv_seen - fv0); end
    checks++; if (fe_seen !== fe0) begin errors++; $display("FAIL wrap_err_pulses: got %0d exp %0d", fe_seen, fe0); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    rd_addr = '0;
    link.sl_in = 1'b0; link.serial_in = 1'b0; link.sel_in = '0;
    model_reset();
    test_reset();
    test_full_frame();
    test_missing();
    test_abort();
    test_back_to_back();
    test_random();
    test_midword_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spectro_frame_rx.md
SPECTRO_FRAME_RX -- requirements
Module: spectro_frame_rx

Interface
REQ-001 Parameter WORD_W, default 12, SHALL set the bit width of each received word.
REQ-002 Parameter N_WORDS, default 16, SHALL set the words per frame: word 0 is the RTC min/sec word, words 1..15 are the channel counts.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the synchronous, active-low reset.
REQ-005 serial_in  input  1  SHALL carry the serial word data from the spectrogram serializer, MSB first.
REQ-006 sl_in  input  1  SHALL be the serializer load strobe; high for one cycle marks a word load.
REQ-007 sel_in  input  4  SHALL carry the word index (a3..a0), sampled together with sl_in.
REQ-008 rd_addr  input  4  SHALL select the published word to read.
REQ-009 rd_data  output  WORD_W  SHALL return the published word at rd_addr.
REQ-010 frame_valid  output  1  SHALL be a one-cycle pulse when a frame is published.
REQ-011 frame_err  output  1  SHALL flag an incomplete frame; valid only while frame_valid is high.
REQ-012 proto_err  output  1  SHALL be a one-cycle pulse on an aborted word.
REQ-013 frame_cnt  output  8  SHALL count published frames.
REQ-014 busy  output  1  SHALL be high while a word is being shifted in.

Function
REQ-015 The FSM SHALL have the states IDLE, SHIFT and COMMIT.
REQ-016 In IDLE or COMMIT, sl_in=1 SHALL latch sel_in into the word address, clear the bit counter and enter SHIFT on the next cycle.
REQ-017 In SHIFT, serial_in SHALL be sampled on each of the WORD_W cycles that follow the sl_in cycle; the first sample is bit WORD_W-1.
REQ-018 After the WORD_W-th sample, the FSM SHALL enter COMMIT; COMMIT SHALL write the word into the capture buffer at the latched address and set that address's bit in a 16-bit received mask.
REQ-019 From COMMIT, the FSM SHALL return to IDLE unless sl_in=1, in which case REQ-016 applies; back-to-back words with no gap SHALL be lossless.
REQ-020 sl_in=1 while in SHIFT SHALL abort the current word, pulse proto_err, leave the buffer and mask unchanged, and restart per REQ-016.
REQ-021 A COMMIT to address N_WORDS-1 SHALL, in the same edge, copy the capture buffer (including the word just written) to the published buffer, pulse frame_valid, and increment frame_cnt.
REQ-022 At that COMMIT, frame_err SHALL be high if the mask including the new bit is not all ones.
REQ-023 At that COMMIT, the mask SHALL be cleared.
REQ-024 frame_cnt SHALL wrap from 255 to 0.
REQ-025 A COMMIT to an address that is already set in the mask SHALL overwrite the word; this is not an error.
REQ-026 rd_data SHALL be registered with one-cycle latency from rd_addr; reading during a publish SHALL return the pre-publish value on that edge.
REQ-027 busy SHALL be high exactly in SHIFT.

Reset
REQ-028 reset=0 SHALL force IDLE and clear the mask, bit counter and frame_cnt, and drive frame_valid, frame_err, proto_err and busy to 0 on the next edge.
REQ-029 Reset SHALL clear both buffers to 0 and drive rd_data to 0.
REQ-030 Reset asserted during SHIFT SHALL discard the partial word, and no COMMIT SHALL follow.

Structure
REQ-031 A shared package SHALL hold WORD_W, N_WORDS, the FSM state encoding and the RTC word field split (min = [11:6], sec = [5:0]).
REQ-032 The serial-to-parallel shift register with its bit counter SHALL be one sub-module, sipo_word_rx; the FSM and buffers SHALL stay in spectro_frame_rx.

Verification
REQ-033 Scenario, full frame: send 16 words, word k = 0x100+k → frame_valid on the COMMIT of word 15, frame_err=0, frame_cnt=1, rd_addr=7 gives rd_data=0x107 one cycle later.
REQ-034 Scenario, missing word: omit word 9 → frame_valid with frame_err=1, word 9 reads its reset/previous value, and the mask is empty afterwards.
REQ-035 Scenario, abort: sl_in pulse after 5 bits of word 3 → proto_err pulses once, and the new word (sel=4, 0xABC) commits correctly.
REQ-036 Scenario, back-to-back: sl_in in the COMMIT cycle of the prior word, repeated for all 16 words → all words captured, frame_err=0.
REQ-037 Scenario, wrap: 256 complete frames → frame_cnt returns to 0, and frame_valid has pulsed 256 times.
REQ-038 Scenario, mid-word reset: reset=0 at bit 6 of word 2 → IDLE, busy=0, no write, and all outputs at reset values.
